// File: rtl/bcd_display_pkg.sv
// Shared constants, types and segment table for the 8-digit serial display driver.
package bcd_display_pkg;

  localparam int unsigned FRAME_W    = 16;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DATA_W     = 4 * NUM_DIGITS;

  // Active-low {dp,g,f,e,d,c,b,a} for a common-anode digit; entry 0 is rightmost.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Frame word as it leaves the block: segments first, so they land in the far 595.
  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
  } frame_t;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } state_t;

endpackage

// File: rtl/bcd_display_seg7_decode.sv
// Hex nibble to active-low 7-segment byte (dp off). Purely combinational.
//   nibble_i : hex digit 0-F
//   seg_o    : {dp,g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/bcd_display.sv
// Scans an 8-digit multiplexed 7-segment display through two cascaded 74HC595s.
// One 16-bit frame {seg, sel} is shifted MSB first per digit slot, then latched.
// Optional: define BCD_DISPLAY_BLANK_LZ_EN to blank leading zero digits.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   lockdata : capture strobe, data register loads every clk it is high
//   data     : 8 hex digits, data[3:0] is digit 0 (rightmost)
//   lock595  : 595 storage latch (RCLK)
//   out595   : 595 serial data (SER)
//   clk595   : 595 shift clock (SRCLK)
module bcd_display
  import bcd_display_pkg::*;
#(
  parameter int unsigned SCLK_DIV       = 4,
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lockdata,
  input  logic [DATA_W-1:0] data,
  output logic              lock595,
  output logic              out595,
  output logic              clk595
);

  localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned SLOT_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned BIT_W  = $clog2(FRAME_W);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    digit_q, digit_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                out595_q, out595_d;
  logic                clk595_q, clk595_d;
  logic                lock595_q, lock595_d;

  logic [3:0]          nibble_c;
  logic [7:0]          seg_raw_c;
  logic [7:0]          seg_c;
  logic [NUM_DIGITS-1:0] sel_c;
  frame_t              frame_c;

  // Capture register; mid-frame updates only reach the next LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          data_q <= '0;
    else if (lockdata) data_q <= data;
  end

  assign nibble_c = data_q[{digit_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i (nibble_c),
    .seg_o    (seg_raw_c)
  );

`ifdef BCD_DISPLAY_BLANK_LZ_EN
  // Blank when this digit and every digit to its left are zero; digit 0 always shows.
  logic blank_c;
  assign blank_c = (digit_q != '0) && ((data_q >> {digit_q, 2'b00}) == '0);
  assign seg_c   = blank_c ? 8'hFF : seg_raw_c;
`else
  assign seg_c   = seg_raw_c;
`endif

  assign sel_c   = NUM_DIGITS'(1) << digit_q;
  assign frame_c = '{seg: seg_c, sel: sel_c};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD;
      digit_q   <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      slot_q    <= '0;
      out595_q  <= 1'b0;
      clk595_q  <= 1'b0;
      lock595_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      slot_q    <= slot_d;
      out595_q  <= out595_d;
      clk595_q  <= clk595_d;
      lock595_q <= lock595_d;
    end
  end

  // Next-state and output logic; slot counter is zero in LOAD so the slot is exactly REFRESH_CYCLES.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    div_d     = div_q;
    slot_d    = slot_q + SLOT_W'(1);
    out595_d  = out595_q;
    clk595_d  = clk595_q;
    lock595_d = lock595_q;

    unique case (state_q)
      LOAD: begin
        shreg_d  = frame_c;
        out595_d = frame_c.seg[7];
        bit_d    = '0;
        div_d    = '0;
        clk595_d = 1'b0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d = '0;
          if (!clk595_q) begin
            clk595_d = 1'b1;
          end else begin
            // Falling edge: present the next bit, or finish and start the latch pulse.
            clk595_d = 1'b0;
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              lock595_d = 1'b1;
              state_d   = LATCH;
            end else begin
              bit_d    = bit_q + BIT_W'(1);
              shreg_d  = shreg_q << 1;
              out595_d = shreg_q[FRAME_W-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d     = '0;
          lock595_d = 1'b0;
          state_d   = HOLD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (slot_q == SLOT_W'(REFRESH_CYCLES - 1)) begin
          slot_d  = '0;
          digit_d = digit_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign lock595 = lock595_q;
  assign out595  = out595_q;
  assign clk595  = clk595_q;

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: expected frames are queued when stimulus is
// applied and compared when the 595 latch pulse marks a complete frame.
module tb_bcd_display;

  localparam int unsigned D = 4;
  localparam int unsigned R = 200;

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        lockdata;
  logic [31:0] data;
  logic        lock595, out595, clk595;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  // Monitor state
  int          cyc = 0;
  int          frames = 0;
  logic [15:0] sr;
  int          nbits, badper, overlap;
  int          last_rise, last_lock, lock_start;
  bit          rise_valid, spacing_valid;
  logic        prev_clk, prev_lock;

  bcd_display #(.SCLK_DIV(D), .REFRESH_CYCLES(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .lockdata (lockdata),
    .data     (data),
    .lock595  (lock595),
    .out595   (out595),
    .clk595   (clk595)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic [31:0] v, input int d);
    logic [7:0] seg;
    logic [7:0] sel;
    logic [3:0] nib;
    nib = 4'(v >> (4 * d));
    seg = SEG_TBL[nib];
`ifdef BCD_DISPLAY_BLANK_LZ_EN
    if (d != 0 && (v >> (4 * d)) == 32'd0) seg = 8'hFF;
`endif
    sel = 8'(1 << d);
    return {seg, sel};
  endfunction

  // Frame reassembly and timing checks on the 595 pins.
  always @(negedge clk) begin
    if (!rst) begin
      sr = '0; nbits = 0; badper = 0; overlap = 0; frames = 0;
      rise_valid = 0; spacing_valid = 0; prev_clk = 0; prev_lock = 0;
    end else begin
      cyc++;
      if (clk595 && lock595) overlap++;
      if (clk595 && !prev_clk) begin
        sr = {sr[14:0], out595};
        nbits++;
        if (rise_valid && (cyc - last_rise) != 2 * D) badper++;
        last_rise = cyc;
        rise_valid = 1;
      end
      if (lock595 && !prev_lock) begin
        check("edges", nbits, 16);
        check("sclk_period", badper, 0);
        check("overlap", overlap, 0);
        if (spacing_valid) check("slot_spacing", cyc - last_lock, R);
        last_lock = cyc;
        spacing_valid = 1;
        if (sb.size() != 0) check("frame", sr, sb.pop_front());
        frames++;
        nbits = 0; badper = 0; overlap = 0; rise_valid = 0;
        lock_start = cyc;
      end
      if (!lock595 && prev_lock) check("lock_width", cyc - lock_start, D);
      prev_clk  = clk595;
      prev_lock = lock595;
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 12 * R) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_lock_fall();
    bit seen = 0;
    for (int n = 0; n < 2 * R; n++) begin
      @(negedge clk);
      if (lock595) seen = 1;
      else if (seen) return;
    end
    check("lock_fall_timeout", 0, 1);
  endtask

  task automatic wait_sclk_rise();
    bit seen_low = 0;
    for (int n = 0; n < 2 * R; n++) begin
      @(negedge clk);
      if (!clk595) seen_low = 1;
      else if (seen_low) return;
    end
    check("sclk_rise_timeout", 0, 1);
  endtask

  task automatic capture(input logic [31:0] v, input int ncyc);
    data = v;
    lockdata = 1'b1;
    repeat (ncyc) @(negedge clk);
    lockdata = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    int n;
    rst = 1'b1; lockdata = 1'b0; data = '0;
    #1 rst = 1'b0;
    #50;
    check("rst_lock595", lock595, 0);
    check("rst_out595", out595, 0);
    check("rst_clk595", clk595, 0);
    #50;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(exp_frame(32'd0, 0));
    wait_drain();

    // Capture in HOLD, then follow a full scan plus wrap.
    cur = 32'h12345678;
    wait_lock_fall();
    capture(cur, 5);
    n = frames % 8;
    for (int k = 0; k < 9; k++) sb.push_back(exp_frame(cur, (n + k) % 8));
    wait_drain();

    // Capture while shifting: current frame keeps the old value.
    wait_sclk_rise();
    n = frames % 8;
    sb.push_back(exp_frame(cur, n));
    capture(32'hABCDEF01, 1);
    cur = 32'hABCDEF01;
    sb.push_back(exp_frame(cur, (n + 1) % 8));
    sb.push_back(exp_frame(cur, (n + 2) % 8));
    wait_drain();

    // Asynchronous reset in the middle of a shift.
    wait_sclk_rise();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_lock595", lock595, 0);
    check("mid_rst_out595", out595, 0);
    check("mid_rst_clk595", clk595, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cur = 32'd0;
    sb.push_back(exp_frame(cur, 0));
    sb.push_back(exp_frame(cur, 1));
    wait_drain();

    // Leading-zero pattern (blanked only when the option is built in).
    cur = 32'h00000305;
    wait_lock_fall();
    capture(cur, 2);
    n = frames % 8;
    for (int k = 0; k < 8; k++) sb.push_back(exp_frame(cur, (n + k) % 8));
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display.md
Name: bcd_display

Overview:
Drives an 8-digit multiplexed 7-segment display through two cascaded 74HC595 shift registers over a 3-wire serial interface (data, shift clock, latch). A 32-bit value holds 8 hex nibbles and is captured on lockdata. The block continuously scans the digits, shifting one 16-bit frame (segment byte plus digit-select byte) per digit. It sits between the system data path and the board display pins.

Parameters:
SCLK_DIV, 4, system clocks per clk595 half-period (min 1)
REFRESH_CYCLES, 50000, system clocks per digit slot, measured from frame start (must exceed 34*SCLK_DIV)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
lockdata  input  1  capture strobe, level-sampled each clk
data  input  32  8 hex digits; data[3:0] is the rightmost digit (digit 0)
lock595  output  1  595 storage-register latch (RCLK)
out595  output  1  595 serial data (SER)
clk595  output  1  595 shift clock (SRCLK)

Behaviour:
- Reset (rst=0, async): lock595=0, out595=0, clk595=0, data register=0, digit index=0, FSM=LOAD, all counters 0.
- Capture: on any clk with lockdata=1, data register <= data. Holding lockdata high re-captures every cycle.
- Snapshot: the current digit's nibble is taken from the data register in LOAD. A capture mid-frame affects the next frame only, so no tearing occurs.
- Decode: hex 0-F to an active-low segment byte {dp,g,f,e,d,c,b,a}, dp always off (1), for a common-anode display:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Digit select byte: active-high one-hot, bit i = digit i.
- Frame: 16 bits = {seg[7:0], sel[7:0]}, shifted MSB first, so seg ends up in the far 595.
- FSM:
  - LOAD (1 clk): build frame; bit counter=0.
  - SHIFT: out595 is updated while clk595 is low. clk595 is low for SCLK_DIV clocks, then high for SCLK_DIV clocks, giving a rising edge mid-bit. After 16 bits, clk595 returns low; go to LATCH.
  - LATCH: lock595=1 for SCLK_DIV clocks, then 0; go to HOLD.
  - HOLD: wait until the slot counter reaches REFRESH_CYCLES-1. Then digit index = (index+1) mod 8 (7 wraps to 0); go to LOAD.
- Slot period is exactly REFRESH_CYCLES clocks; full scan = 8*REFRESH_CYCLES.
- clk595 and lock595 are never high simultaneously. clk595 idles low outside SHIFT. out595 holds its last bit outside SHIFT.
- Reset mid-frame aborts immediately. After release the FSM restarts at digit 0 with the register cleared, so "00000000" is shown until a capture.

Optional Feature:
BCD_DISPLAY_BLANK_LZ_EN
- Defined: leading zero digits (digit 7 down to the first nonzero digit) shift seg=FF (blank). Digit 0 is never blanked, so value 0 shows a single "0". Select and timing are unchanged.
- Undefined: all 8 digits are always shown.

Decomposition:
- Package bcd_display_pkg: FRAME_W=16, NUM_DIGITS=8, the 16-entry segment lookup constant, and the FSM state enum (LOAD, SHIFT, LATCH, HOLD).
- One sub-module: seg7_decode (4-bit nibble in, 8-bit active-low segments out, purely combinational).
- Top level contains the FSM, counters and capture register.

Test Plan:
- Reset: rst=0 for 100 ns, then release; lockdata never asserted -> first frame decodes 0xC001 and outputs are 0 during reset.
- Capture and display: data=32'h12345678, lockdata pulse 5 clks -> on the next frames the decoded frames are 0x8001 (8), 0xF802 (7), 0x8204 (6), 0x9208 (5), 0x9910 (4), 0xB020 (3), 0xA440 (2), 0xF980 (1), then wrap to 0x8001.
- Timing: with SCLK_DIV=4, REFRESH_CYCLES=50000 -> exactly 16 clk595 rising edges per frame, each period 8 clks; one lock595 pulse 4 clks wide after the last clk595 falls; frame starts spaced 50000 clks apart; no overlap of lock595 and clk595.
- Mid-frame capture: change data to 32'hABCDEF01 with lockdata during SHIFT -> the current frame is unchanged; the following frame uses the new value (digit n+1 nibble).
- Async reset mid-SHIFT: assert rst between clk edges -> all outputs are 0 immediately; after release, the scan restarts at digit 0 showing 0.
- BCD_DISPLAY_BLANK_LZ_EN defined, data=32'h00000305 -> digits 7..3 show FF; digits 2..0 show B0, C0, 92.
